// File: rtl/lsu_mem_port_ctrl.sv
// Load/store initiator for a dual-port word memory: splits each byte-addressed
// access into word n on port A and word n+1 on port B, then realigns load data.
module lsu_mem_port_ctrl #(
  parameter int MEM_WORDS = 512
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic [15:0] o_mem_addr_a,
  output logic [15:0] o_mem_addr_b,
  output logic [31:0] o_mem_wdata_a,
  output logic [31:0] o_mem_wdata_b,
  output logic [3:0]  o_mem_bmask_a,
  output logic [3:0]  o_mem_bmask_b,
  output logic        o_mem_wren_a,
  output logic        o_mem_wren_b,
  input  logic [31:0] i_mem_rdata_a,
  input  logic [31:0] i_mem_rdata_b
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [16:0] WORDS     = 17'(MEM_WORDS);
  localparam logic [16:0] LAST_WORD = 17'(MEM_WORDS - 1);

  state_t      state, state_nxt;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic [15:0] n;
  logic [1:0]  off;
  logic [7:0]  smask;
  logic [7:0]  mask8;
  logic        crossing;
  logic        err;
  logic [63:0] wide_wdata;
  logic [63:0] r64;
  logic [31:0] load_data;

  // NOTE: every variable assigned in an always_comb gets a default on entry,
  // so no path through the block can leave a value held (no latch inferred).
  always_comb begin
    n        = req_addr[17:2];
    off      = req_addr[1:0];
    case (req_size)
      2'd0:    smask = 8'h01;
      2'd1:    smask = 8'h03;
      2'd2:    smask = 8'h0F;
      default: smask = 8'h00;
    endcase
    mask8    = smask << off;
    crossing = |mask8[7:4];
    err      = (req_size == 2'd3) || (|req_addr[31:18]) ||
               ({1'b0, n} >= WORDS) || (crossing && ({1'b0, n} == LAST_WORD));
    wide_wdata = {32'h0, req_wdata} << {off, 3'b000};
    r64        = {i_mem_rdata_b, i_mem_rdata_a} >> {off, 3'b000};
    case (req_size)
      2'd0:    load_data = req_unsigned ? {24'h0, r64[7:0]}
                                        : {{24{r64[7]}}, r64[7:0]};
      2'd1:    load_data = req_unsigned ? {16'h0, r64[15:0]}
                                        : {{16{r64[15]}}, r64[15:0]};
      default: load_data = r64[31:0];
    endcase
    // Stores and rejected requests always answer with zero data.
    if (req_we || err) load_data = 32'h0;
  end

  // NOTE: sequential state uses non-blocking assignments only, and the
  // asynchronous reset is in the sensitivity list so it acts without a clock.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= IDLE;
      req_we       <= 1'b0;
      req_size     <= 2'd0;
      req_unsigned <= 1'b0;
      req_addr     <= 32'h0;
      req_wdata    <= 32'h0;
      rsp_rdata    <= 32'h0;
      rsp_err      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && i_req_valid) begin
        req_we       <= i_req_we;
        req_size     <= i_req_size;
        req_unsigned <= i_req_unsigned;
        req_addr     <= i_req_addr;
        req_wdata    <= i_req_wdata;
      end
      if (state == ACCESS) begin
        rsp_rdata <= load_data;
        rsp_err   <= err;
      end
    end
  end

  // Memory ports are driven only while in ACCESS, so reset (which forces
  // IDLE asynchronously) drops the write enables immediately.
  always_comb begin
    state_nxt     = state;
    o_req_ready   = 1'b0;
    o_rsp_valid   = 1'b0;
    o_mem_addr_a  = 16'h0;
    o_mem_addr_b  = 16'h0;
    o_mem_wdata_a = 32'h0;
    o_mem_wdata_b = 32'h0;
    o_mem_bmask_a = 4'h0;
    o_mem_bmask_b = 4'h0;
    o_mem_wren_a  = 1'b0;
    o_mem_wren_b  = 1'b0;
    case (state)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) state_nxt = ACCESS;
      end
      ACCESS: begin
        o_mem_addr_a  = n;
        o_mem_addr_b  = n + 16'd1;
        o_mem_wdata_a = wide_wdata[31:0];
        o_mem_wdata_b = wide_wdata[63:32];
        o_mem_bmask_a = mask8[3:0];
        o_mem_bmask_b = mask8[7:4];
        o_mem_wren_a  = req_we && !err && (mask8[3:0] != 4'h0);
        o_mem_wren_b  = req_we && !err && crossing;
        state_nxt     = RESP;
      end
      RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_rsp_rdata = rsp_rdata;
  assign o_rsp_err   = rsp_err;

endmodule

// File: doc/lsu_mem_port_ctrl.md
Name: lsu_mem_port_ctrl

Overview:
- Initiator side of the banked dual-port data memory: the load/store unit that drives both memory ports.
- Accepts one byte-addressed load/store request at a time over a valid/ready handshake.
- Splits any access, including misaligned ones, into a word-n access on port A and a word-n+1 access on port B, with byte masks and shifted write data.
- Realigns and sign/zero-extends load data. Returns a response over a second valid/ready handshake.

Parameters:
MEM_WORDS, 512, number of 32-bit words in the attached memory; legal word indices 0..MEM_WORDS-1

Ports:
i_clk  input  1  clock, all state on rising edge
i_reset  input  1  asynchronous, active-high reset
i_req_valid  input  1  request valid
o_req_ready  output  1  request accepted when valid&ready at clock edge
i_req_we  input  1  1 = store, 0 = load
i_req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal
i_req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend
i_req_addr  input  32  byte address
i_req_wdata  input  32  store data, right-justified
o_rsp_valid  output  1  response valid
i_rsp_ready  input  1  response consumed when valid&ready at clock edge
o_rsp_rdata  output  32  aligned, extended load data; 0 for stores and errors
o_rsp_err  output  1  request rejected, no memory write performed
o_mem_addr_a  output  16  word index n
o_mem_addr_b  output  16  word index n+1, modulo 2^16
o_mem_wdata_a  output  32  port A write data
o_mem_wdata_b  output  32  port B write data
o_mem_bmask_a  output  4  port A byte enables
o_mem_bmask_b  output  4  port B byte enables
o_mem_wren_a  output  1  port A write enable
o_mem_wren_b  output  1  port B write enable
i_mem_rdata_a  input  32  combinational read of word at o_mem_addr_a
i_mem_rdata_b  input  32  combinational read of word at o_mem_addr_b

Behaviour:
- Reset: one clock, i_clk; reset is asynchronous and active-high on i_reset.
- Reset values:
  - State IDLE; o_req_ready=1 once reset deasserts.
  - o_rsp_valid=0, o_rsp_err=0, o_rsp_rdata=0.
  - All o_mem_* = 0.
  - Assertion immediately forces o_mem_wren_a/b low. A request in flight is dropped with no response.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE.
  - IDLE: o_req_ready=1. On i_req_valid=1, latch all request fields and go to ACCESS.
  - ACCESS: lasts exactly 1 cycle; o_req_ready=0. Drive memory ports from the latched request. Register the aligned load data and err at the end of the cycle. Go to RESP.
  - RESP: o_rsp_valid=1; o_rsp_rdata and o_rsp_err held stable. Stay while i_rsp_ready=0. Return to IDLE on i_rsp_ready=1. No new request is accepted in the same cycle.
- Latency: request accepted at edge k; memory access in cycle k..k+1; o_rsp_valid rises after edge k+1. Throughput: 1 request per 3 cycles maximum.
- Address decode:
  - n = addr[17:2]; off = addr[1:0].
  - smask = 0x1 / 0x3 / 0xF for size 0/1/2.
  - mask8 = smask << off.
  - crossing = (mask8[7:4] != 0).
- Error when any of the following holds; on error no wren, rsp_err=1, rsp_rdata=0:
  - size==3.
  - addr[31:18] != 0.
  - n >= MEM_WORDS.
  - crossing and n == MEM_WORDS-1.
- Port drive in ACCESS:
  - addr_a=n, addr_b=n+1. Port B always has opposite bank parity from port A.
  - bmask_a=mask8[3:0], bmask_b=mask8[7:4].
  - {wdata_b,wdata_a} = zero-extended 64-bit wdata << (8*off).
  - wren_a = we & !err & (bmask_a != 0).
  - wren_b = we & !err & crossing.
- Outside ACCESS: all wren/bmask = 0, addr/wdata = 0.
- Load: r64 = {rdata_b,rdata_a} >> (8*off). Truncate to 8/16/32 bits, then sign- or zero-extend per i_req_unsigned. Size 2 ignores i_req_unsigned.
- Store response: rdata=0, err per the rules above.

Test Plan:
Preload word5=0x44332211, word6=0x88776655 for all directed cases.
1. LW addr=0x14 -> ACCESS addr_a=5, addr_b=6, wren=0; after 2 edges rsp_valid=1, rdata=0x44332211, err=0.
2. LW addr=0x17 (misaligned) -> rdata=0x77665544; LH signed addr=0x17 -> 0x00005544.
3. LB addr=0x1B signed -> 0xFFFFFF88; same request with unsigned=1 -> 0x00000088.
4. SW 0xAABBCCDD addr=0x16 -> in ACCESS: bmask_a=0xC, bmask_b=0x3, wdata_a=0xCCDD0000, wdata_b=0x0000AABB, both wren=1; readback word5=0xCCDD2211, word6=0x8877AABB.
5. Errors: SW addr=0x7FD (n=511, crossing) -> err=1, rdata=0, both wren stay 0. size=3 and addr=0x800 (n=512) -> err=1.
6. Handshakes:
   - Hold i_rsp_ready=0 for 3 cycles -> rsp_valid/rdata stable, req_ready=0, i_req_valid ignored.
   - Assert i_reset mid-ACCESS of a store -> wren drops immediately, no write, no response; req_ready=1 after deassert.
